// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants and types for the ID/EX boundary
package id_ex_stage_pkg;

    // Forward-select encoding used by the per-operand mux
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EALU = 2'd1;
    localparam logic [1:0] FWD_MALU = 2'd2;
    localparam logic [1:0] FWD_MMO  = 2'd3;

    localparam int ALUC_W = 4;

    // Control bundle carried into the EX stage
    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              aluimm;
        logic              shift;
        logic              jal;
        logic [ALUC_W-1:0] aluc;
    } ectl_t;

    // Value loaded on reset and on bubble cycles
    localparam ectl_t CTL_ZERO = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - one operand's forward select and 4:1 data mux
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] rn,
    input  logic [DW-1:0] q,
    input  logic [RW-1:0] ern,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic [DW-1:0] ealu,
    input  logic [RW-1:0] mrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mmo,
    output logic [DW-1:0] d
);

    logic [1:0] sel;

    // Youngest producer wins; r0 is never forwarded and EX loads cannot forward
    always_comb begin
        sel = FWD_RF;
        if (ewreg && !em2reg && (ern != '0) && (ern == rn)) begin
            sel = FWD_EALU;
        end else if (mwreg && (mrn != '0) && (mrn == rn)) begin
            sel = mm2reg ? FWD_MMO : FWD_MALU;
        end
    end

    // Operand data selected by the forward code
    always_comb begin
        unique case (sel)
            FWD_EALU: d = ealu;
            FWD_MALU: d = malu;
            FWD_MMO:  d = mmo;
            default:  d = q;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and stall counter
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RW-1:0]     rna,
    input  logic [RW-1:0]     rnb,
    input  logic [DW-1:0]     qa,
    input  logic [DW-1:0]     qb,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [DW-1:0]     imm,
    input  logic [DW-1:0]     dpc4,
    input  logic [RW-1:0]     drn,
    input  logic              dwreg,
    input  logic              dm2reg,
    input  logic              dwmem,
    input  logic              daluimm,
    input  logic              dshift,
    input  logic              djal,
    input  logic [ALUC_W-1:0] daluc,
    input  logic [RW-1:0]     ern,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic [DW-1:0]     ealu,
    input  logic [RW-1:0]     mrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [DW-1:0]     malu,
    input  logic [DW-1:0]     mmo,
    input  logic              flush,
    output logic              wpcir,
    output logic [DW-1:0]     ea,
    output logic [DW-1:0]     eb,
    output logic [DW-1:0]     eimm,
    output logic [DW-1:0]     epc4,
    output logic [RW-1:0]     ern_o,
    output logic              ewreg_o,
    output logic              em2reg_o,
    output logic              ewmem_o,
    output logic              ealuimm_o,
    output logic              eshift_o,
    output logic              ejal_o,
    output logic [ALUC_W-1:0] ealuc_o,
    output logic [CW-1:0]     stall_cnt
);

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          stall;
    logic          bubble;
    ectl_t         dctl;
    ectl_t         ectl;

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .rn(rna), .q(qa), .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ealu(ealu),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mmo(mmo), .d(fwd_a)
    );

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .rn(rnb), .q(qb), .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ealu(ealu),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mmo(mmo), .d(fwd_b)
    );

    // Load in EX feeding a source that ID actually reads; reset masks it
    always_comb begin
        stall  = !rst && ewreg && em2reg && (ern != '0) &&
                 ((use_rs && (ern == rna)) || (use_rt && (ern == rnb)));
        bubble = stall || flush;
        wpcir  = !stall || flush;
        dctl   = '{wreg: dwreg, m2reg: dm2reg, wmem: dwmem, aluimm: daluimm,
                   shift: dshift, jal: djal, aluc: daluc};
    end

    // ID/EX register: data always advances, controls and destination squashed on bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            ea    <= '0;
            eb    <= '0;
            eimm  <= '0;
            epc4  <= '0;
            ern_o <= '0;
            ectl  <= CTL_ZERO;
        end else begin
            ea    <= fwd_a;
            eb    <= fwd_b;
            eimm  <= imm;
            epc4  <= dpc4;
            ern_o <= bubble ? '0 : drn;
            ectl  <= bubble ? CTL_ZERO : dctl;
        end
    end

    // Counts cycles lost to load-use stalls; a flushed stall is not a lost cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !flush) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign ewreg_o   = ectl.wreg;
    assign em2reg_o  = ectl.m2reg;
    assign ewmem_o   = ectl.wmem;
    assign ealuimm_o = ectl.aluimm;
    assign eshift_o  = ectl.shift;
    assign ejal_o    = ectl.jal;
    assign ealuc_o   = ectl.aluc;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rna, rnb, drn, ern, mrn;
    logic [31:0] qa, qb, imm, dpc4, ealu, malu, mmo;
    logic        use_rs, use_rt, dwreg, dm2reg, dwmem, daluimm, dshift, djal;
    logic [3:0]  daluc;
    logic        ewreg, em2reg, mwreg, mm2reg, flush;

    logic        wpcir, wpcir4;
    logic [31:0] ea, eb, eimm, epc4, ea4, eb4, eimm4, epc44;
    logic [4:0]  ern_o, ern_o4;
    logic        ewreg_o, em2reg_o, ewmem_o, ealuimm_o, eshift_o, ejal_o;
    logic        ewreg_o4, em2reg_o4, ewmem_o4, ealuimm_o4, eshift_o4, ejal_o4;
    logic [3:0]  ealuc_o, ealuc_o4;
    logic [31:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .use_rs(use_rs), .use_rt(use_rt), .imm(imm), .dpc4(dpc4), .drn(drn),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
        .dshift(dshift), .djal(djal), .daluc(daluc), .ern(ern), .ewreg(ewreg),
        .em2reg(em2reg), .ealu(ealu), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .malu(malu), .mmo(mmo), .flush(flush), .wpcir(wpcir), .ea(ea), .eb(eb),
        .eimm(eimm), .epc4(epc4), .ern_o(ern_o), .ewreg_o(ewreg_o),
        .em2reg_o(em2reg_o), .ewmem_o(ewmem_o), .ealuimm_o(ealuimm_o),
        .eshift_o(eshift_o), .ejal_o(ejal_o), .ealuc_o(ealuc_o), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CW(4)) dut4 (
        .clk(clk), .rst(rst), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .use_rs(use_rs), .use_rt(use_rt), .imm(imm), .dpc4(dpc4), .drn(drn),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
        .dshift(dshift), .djal(djal), .daluc(daluc), .ern(ern), .ewreg(ewreg),
        .em2reg(em2reg), .ealu(ealu), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .malu(malu), .mmo(mmo), .flush(flush), .wpcir(wpcir4), .ea(ea4), .eb(eb4),
        .eimm(eimm4), .epc4(epc44), .ern_o(ern_o4), .ewreg_o(ewreg_o4),
        .em2reg_o(em2reg_o4), .ewmem_o(ewmem_o4), .ealuimm_o(ealuimm_o4),
        .eshift_o(eshift_o4), .ejal_o(ejal_o4), .ealuc_o(ealuc_o4), .stall_cnt(stall_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [4:0] rn, input logic [31:0] q);
        if (ewreg && !em2reg && ern != 0 && ern == rn) return ealu;
        if (mwreg && mrn != 0 && mrn == rn) return mm2reg ? mmo : malu;
        return q;
    endfunction

    function automatic logic m_stall();
        return ewreg && em2reg && ern != 0 &&
               ((use_rs && ern == rna) || (use_rt && ern == rnb));
    endfunction

    logic [31:0] x_ea, x_eb, x_eimm, x_epc4;
    logic [4:0]  x_ern;
    logic [9:0]  x_ctl;
    int unsigned x_cnt;
    bit          valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            x_ea = 0; x_eb = 0; x_eimm = 0; x_epc4 = 0; x_ern = 0; x_ctl = 0; x_cnt = 0;
        end else begin
            x_ea   = m_fwd(rna, qa);
            x_eb   = m_fwd(rnb, qb);
            x_eimm = imm;
            x_epc4 = dpc4;
            if (m_stall() || flush) begin
                x_ern = 0;
                x_ctl = 0;
            end else begin
                x_ern = drn;
                x_ctl = {dwreg, dm2reg, dwmem, daluimm, dshift, djal, daluc};
            end
            if (m_stall() && !flush) x_cnt++;
        end
        if (rst) valid = 1;
    end

    // Every cycle after the first reset edge: both instances against the model
    always @(negedge clk) begin
        if (valid) begin
            check("ea", ea, x_ea);
            check("eb", eb, x_eb);
            check("eimm", eimm, x_eimm);
            check("epc4", epc4, x_epc4);
            check("ern_o", 32'(ern_o), 32'(x_ern));
            check("ctl", 32'({ewreg_o, em2reg_o, ewmem_o, ealuimm_o, eshift_o, ejal_o, ealuc_o}), 32'(x_ctl));
            check("stall_cnt", stall_cnt, x_cnt);
            check("stall_cnt4", 32'(stall_cnt4), x_cnt % 16);
            check("ea4", ea4, x_ea);
            check("wpcir", 32'(wpcir), 32'(rst || flush || !m_stall()));
            check("wpcir4", 32'(wpcir4), 32'(rst || flush || !m_stall()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rna = 0; rnb = 0; qa = 0; qb = 0; use_rs = 0; use_rt = 0;
        imm = 32'h10; dpc4 = 32'h400; drn = 5'd9;
        dwreg = 1; dm2reg = 0; dwmem = 1; daluimm = 1; dshift = 1; djal = 1; daluc = 4'hA;
        ern = 0; ewreg = 0; em2reg = 0; ealu = 0; mrn = 0; mwreg = 0; mm2reg = 0;
        malu = 0; mmo = 0; flush = 0;
    endtask

    task automatic load_hazard();
        ern = 7; ewreg = 1; em2reg = 1; rnb = 7; use_rt = 1; qb = 32'h77;
    endtask

    initial begin
        rst = 1;
        idle();
        load_hazard();
        ealu = 32'h5;
        #1;
        check("wpcir_in_reset", 32'(wpcir), 32'd1);
        cyc();
        check("reset_ea", ea, 0);
        check("reset_ctl", 32'(ewreg_o), 0);
        check("reset_cnt", stall_cnt, 0);
        rst = 0;
        idle();

        // EX forward
        rna = 3; ern = 3; ewreg = 1; em2reg = 0; ealu = 32'h1234; qa = 32'hDEAD;
        #1;
        check("exfwd_wpcir", 32'(wpcir), 1);
        cyc();
        check("exfwd_ea", ea, 32'h1234);

        // EX beats MEM; r0 never forwards
        idle();
        rna = 5; rnb = 5; ern = 5; ewreg = 1; mrn = 5; mwreg = 1; ealu = 32'hA; malu = 32'hB;
        qa = 32'h1; qb = 32'h2;
        cyc();
        check("prio_ea", ea, 32'hA);
        check("prio_eb", eb, 32'hA);
        idle();
        rna = 0; ern = 0; ewreg = 1; ealu = 32'h99; mrn = 0; mwreg = 1; malu = 32'h98;
        cyc();
        check("r0_ea", ea, 0);

        // MEM ALU forward, use bits clear
        idle();
        rnb = 4; mrn = 4; mwreg = 1; malu = 32'hBEEF; qb = 32'h3;
        cyc();
        check("memfwd_eb", eb, 32'hBEEF);

        // Load-use stall then resolve through MEM load data
        idle();
        load_hazard();
        #1;
        check("lu_wpcir", 32'(wpcir), 0);
        cyc();
        check("lu_ewreg", 32'(ewreg_o), 0);
        check("lu_ern", 32'(ern_o), 0);
        check("lu_eb_data", eb, 32'h77);
        check("lu_cnt", stall_cnt, 1);
        idle();
        rnb = 7; use_rt = 1; mrn = 7; mwreg = 1; mm2reg = 1; mmo = 32'h55;
        #1;
        check("lu2_wpcir", 32'(wpcir), 1);
        cyc();
        check("lu2_eb", eb, 32'h55);
        check("lu2_ewreg", 32'(ewreg_o), 1);

        // Same hazard but no operand is used
        idle();
        load_hazard();
        use_rt = 0;
        #1;
        check("gate_wpcir", 32'(wpcir), 1);
        cyc();
        check("gate_ern", 32'(ern_o), 9);
        check("gate_cnt", stall_cnt, 1);

        // Flush and stall together
        idle();
        load_hazard();
        flush = 1;
        #1;
        check("fs_wpcir", 32'(wpcir), 1);
        cyc();
        check("fs_ejal", 32'(ejal_o), 0);
        check("fs_cnt", stall_cnt, 1);

        // Reset in the middle of a stall
        idle();
        load_hazard();
        cyc();
        check("rs_pre_cnt", stall_cnt, 2);
        rst = 1;
        cyc();
        check("rs_eb", eb, 0);
        check("rs_epc4", epc4, 0);
        check("rs_cnt", stall_cnt, 0);
        rst = 0;
        #1;
        check("rs_after_wpcir", 32'(wpcir), 0);

        // 16 stall cycles wrap the 4-bit counter
        repeat (16) cyc();
        check("wrap_cnt4", 32'(stall_cnt4), 0);
        check("wrap_cnt32", stall_cnt, 16);

        // Mixed vectors over a small register range
        for (int i = 0; i < 40; i++) begin
            rna = 5'($urandom_range(0, 3)); rnb = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
            qa = $urandom; qb = $urandom; ealu = $urandom; malu = $urandom; mmo = $urandom;
            imm = $urandom; dpc4 = $urandom; drn = 5'($urandom);
            {ewreg, em2reg, mwreg, mm2reg, use_rs, use_rt} = 6'($urandom);
            {dwreg, dm2reg, dwmem, daluimm, dshift, djal} = 6'($urandom);
            daluc = 4'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            cyc();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage pipeline; consumes the register-file read ports (qa, qb) during ID.
- Resolves operand forwarding from the EX and MEM stages and detects load-use hazards.
- Stalls PC/IF-ID on a load-use hazard and registers the ID results into EX-stage state.
- Inserts bubbles on stall or flush and keeps a stall-cycle performance counter.

Parameters:
- DW, 32, datapath width
- RW, 5, register-number width
- CW, 32, stall counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- rna  in  RW  rs number (ID)
- rnb  in  RW  rt number (ID)
- qa  in  DW  regfile port A
- qb  in  DW  regfile port B
- use_rs  in  1  ID instruction reads rs
- use_rt  in  1  ID instruction reads rt
- imm  in  DW  extended immediate
- dpc4  in  DW  PC+4 of ID instruction
- drn  in  RW  ID destination
- dwreg, dm2reg, dwmem, daluimm, dshift, djal  in  1 each  ID controls
- daluc  in  4  ALU control
- ern  in  RW  EX destination
- ewreg, em2reg  in  1 each  EX controls
- ealu  in  DW  EX ALU result
- mrn  in  RW  MEM destination
- mwreg, mm2reg  in  1 each  MEM controls
- malu  in  DW  MEM ALU result
- mmo  in  DW  MEM load data
- flush  in  1  squash ID instruction (taken branch/jump)
- wpcir  out  1  0 = hold PC and IF/ID
- ea, eb, eimm, epc4  out  DW  registered operands
- ern_o  out  RW  registered destination
- ewreg_o, em2reg_o, ewmem_o, ealuimm_o, eshift_o, ejal_o  out  1 each  registered controls
- ealuc_o  out  4  registered ALU control
- stall_cnt  out  CW  count of stall cycles

Behaviour:
- Regfile writes on negedge, so WB data is already visible in qa/qb within the cycle; no WB forwarding.
- Forward select per operand (rs shown; rt identical with rnb, qb, use_rt), first match wins:
  - EX: ewreg & ~em2reg & ern!=0 & ern==rna -> ealu.
  - MEM: mwreg & mrn!=0 & mrn==rna -> malu if ~mm2reg, else mmo.
  - Otherwise -> qa.
- Register number 0 never forwards; a source of r0 always yields qa/qb (0).
- Forwarding applies whether or not use_rs/use_rt is set; the use bits gate only the stall.
- stall = ewreg & em2reg & ern!=0 & ((use_rs & ern==rna) | (use_rt & ern==rnb)).
- wpcir = ~stall | flush. It is combinational, and 1 during reset.
- bubble = stall | flush. On a bubble cycle:
  - all registered control outputs load 0 and ern_o loads 0;
  - data outputs load their normal values.
- Otherwise all E outputs load the forwarded operands and the ID fields.
- Latency: 1 cycle from ID inputs to E outputs.
- stall_cnt increments by 1 on every cycle with stall=1 and flush=0. It wraps modulo 2^CW.
- flush and stall in the same cycle: flush dominates. A bubble is inserted, wpcir=1, and the cycle is not counted.
- Reset (rst=1 at posedge): every E output and stall_cnt go to 0, overriding stall/flush.
- Reset mid-stall: the stall condition is ignored during reset; after reset, stall is re-evaluated from live inputs.

Decomposition:
- Shared package holds the forward-select encoding constants (FWD_RF=0, FWD_EALU=1, FWD_MALU=2, FWD_MMO=3), the ALUC width, and the reset/bubble zero vector.
- One sub-module, fwd_mux: per-operand forward select plus 4:1 mux, instantiated twice (rs, rt).
- Stall logic, pipeline register and counter live in the top level.

Test Plan:
- EX forward: rna=3, ern=3, ewreg=1, em2reg=0, ealu=0x1234, qa=0xDEAD -> next cycle ea=0x1234, wpcir stays 1.
- Priority: rna=rnb=5, EX and MEM both write r5 (ealu=0xA, malu=0xB) -> ea=eb=0xA. With EX writing r0 and rna=0 -> ea=0 (qa).
- Load-use: ern=7, ewreg=em2reg=1, rnb=7, use_rt=1 -> wpcir=0; next edge E controls all 0, stall_cnt=1. Next cycle, the hazard moves to MEM (mm2reg=1, mmo=0x55) -> eb=0x55, wpcir=1.
- use gating: same hazard with use_rt=0 and use_rs=0 -> wpcir=1, no bubble, stall_cnt unchanged.
- Flush+stall together -> wpcir=1, bubble loaded, stall_cnt unchanged.
- Reset: assert rst during an active stall with E outputs non-zero -> after one edge all outputs and stall_cnt=0. Counter wrap checked with CW=4: 16 stall cycles -> 0.
